// File: rtl/redundancy_analyzer_seq_if.sv
// ---------------------------------------------------------------------------
// redundancy_analyzer_seq_if : CAM snapshot inputs and analysis results bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface redundancy_analyzer_seq_if #(
   parameter int PCAM  = 8,
   parameter int NPCAM = 30,
   parameter int ROW_W = 5,
   parameter int COL_W = 5
);
   localparam int USE_W  = $clog2(PCAM + 1);
   localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;

   logic                     start;
   logic [PCAM-1:0]          pivot_valid;
   logic [PCAM*ROW_W-1:0]    pivot_row;
   logic [PCAM*COL_W-1:0]    pivot_col;
   logic [NPCAM-1:0]         npivot_valid;
   logic [NPCAM*ROW_W-1:0]   npivot_row;
   logic [NPCAM*COL_W-1:0]   npivot_col;
   logic                     busy;
   logic                     done;
   logic                     repairable;
   logic [PCAM-1:0]          repair_mask;
   logic [USE_W-1:0]         rows_used;
   logic [USE_W-1:0]         cols_used;
   logic                     extra_valid;
   logic                     extra_is_row;
   logic [ADDR_W-1:0]        extra_addr;

   modport master (
      output start, pivot_valid, pivot_row, pivot_col,
             npivot_valid, npivot_row, npivot_col,
      input  busy, done, repairable, repair_mask, rows_used, cols_used,
             extra_valid, extra_is_row, extra_addr
   );

   modport slave (
      input  start, pivot_valid, pivot_row, pivot_col,
             npivot_valid, npivot_row, npivot_col,
      output busy, done, repairable, repair_mask, rows_used, cols_used,
             extra_valid, extra_is_row, extra_addr
   );
endinterface

`default_nettype wire

// File: rtl/redundancy_analyzer_seq.sv
// ---------------------------------------------------------------------------
// redundancy_analyzer_seq : exhaustive row/column pivot assignment search,
// one candidate per clock. Optional leftover-spare cover: REMAIN_COVER_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module redundancy_analyzer_seq #(
   parameter int PCAM      = 8,
   parameter int NPCAM     = 30,
   parameter int ROW_W     = 5,
   parameter int COL_W     = 5,
   parameter int SPARE_ROW = 4,
   parameter int SPARE_COL = 4
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   redundancy_analyzer_seq_if.slave  bus
);
   localparam int USE_W  = $clog2(PCAM + 1);
   localparam int UNC_W  = $clog2(NPCAM + 1);
   localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;
   localparam logic [31:0] SR_U = SPARE_ROW;
   localparam logic [31:0] SC_U = SPARE_COL;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVAL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q;
   logic [PCAM-1:0]        cnt_q;
   logic [PCAM-1:0]        pv_q;
   logic [PCAM*ROW_W-1:0]  pr_q;
   logic [PCAM*COL_W-1:0]  pc_q;
   logic [NPCAM-1:0]       nv_q;
   logic [NPCAM*ROW_W-1:0] nr_q;
   logic [NPCAM*COL_W-1:0] nc_q;

   logic                   busy_q, done_q, rep_q, xv_q, xrow_q;
   logic [PCAM-1:0]        mask_q;
   logic [USE_W-1:0]       rows_q, cols_q;
   logic [ADDR_W-1:0]      xaddr_q;

   logic                   skip_d, feas_d, pass_d, hit_d;
   logic [USE_W-1:0]       r_d, c_d;
   logic [31:0]            r_ext_d, c_ext_d;
   logic [UNC_W-1:0]       unc_d;
   logic                   xv_d, xrow_d;
   logic [ADDR_W-1:0]      xaddr_d;
`ifdef REMAIN_COVER_EN
   logic [ROW_W-1:0]       urow_d;
   logic [COL_W-1:0]       ucol_d;
`endif

   // Candidate evaluation: cnt_q is the row(1)/column(0) assignment mask.
   always_comb begin
      skip_d = |(cnt_q & ~pv_q);
      r_d    = '0;
      c_d    = '0;
      for (int i = 0; i < PCAM; i++) begin
         if (pv_q[i]) begin
            if (cnt_q[i]) r_d = r_d + USE_W'(1);
            else          c_d = c_d + USE_W'(1);
         end
      end
      r_ext_d = {{(32-USE_W){1'b0}}, r_d};
      c_ext_d = {{(32-USE_W){1'b0}}, c_d};
      feas_d  = (r_ext_d <= SR_U) && (c_ext_d <= SC_U);

      unc_d = '0;
      hit_d = 1'b0;
`ifdef REMAIN_COVER_EN
      urow_d = '0;
      ucol_d = '0;
`endif
      for (int j = 0; j < NPCAM; j++) begin
         hit_d = 1'b0;
         for (int i = 0; i < PCAM; i++) begin
            if (pv_q[i] && (cnt_q[i]
                  ? (pr_q[i*ROW_W +: ROW_W] == nr_q[j*ROW_W +: ROW_W])
                  : (pc_q[i*COL_W +: COL_W] == nc_q[j*COL_W +: COL_W])))
               hit_d = 1'b1;
         end
         if (nv_q[j] && !hit_d) begin
            unc_d = unc_d + UNC_W'(1);
`ifdef REMAIN_COVER_EN
            urow_d = nr_q[j*ROW_W +: ROW_W];
            ucol_d = nc_q[j*COL_W +: COL_W];
`endif
         end
      end

      pass_d  = !skip_d && feas_d && (unc_d == '0);
      xv_d    = 1'b0;
      xrow_d  = 1'b0;
      xaddr_d = '0;
`ifdef REMAIN_COVER_EN
      // A single stray fault may take one leftover spare, row preferred.
      if (!skip_d && feas_d && (unc_d == UNC_W'(1)) &&
          ((r_ext_d + c_ext_d) < (SR_U + SC_U))) begin
         pass_d = 1'b1;
         xv_d   = 1'b1;
         if (r_ext_d < SR_U) begin
            xrow_d  = 1'b1;
            xaddr_d = ADDR_W'(urow_d);
         end else begin
            xaddr_d = ADDR_W'(ucol_d);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pv_q    <= '0;
         pr_q    <= '0;
         pc_q    <= '0;
         nv_q    <= '0;
         nr_q    <= '0;
         nc_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rep_q   <= 1'b0;
         mask_q  <= '0;
         rows_q  <= '0;
         cols_q  <= '0;
         xv_q    <= 1'b0;
         xrow_q  <= 1'b0;
         xaddr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  pv_q    <= bus.pivot_valid;
                  pr_q    <= bus.pivot_row;
                  pc_q    <= bus.pivot_col;
                  nv_q    <= bus.npivot_valid;
                  nr_q    <= bus.npivot_row;
                  nc_q    <= bus.npivot_col;
                  cnt_q   <= '0;
                  rep_q   <= 1'b0;
                  mask_q  <= '0;
                  rows_q  <= '0;
                  cols_q  <= '0;
                  xv_q    <= 1'b0;
                  xrow_q  <= 1'b0;
                  xaddr_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (pass_d) begin
                  rep_q   <= 1'b1;
                  mask_q  <= cnt_q;
                  rows_q  <= r_d;
                  cols_q  <= c_d;
                  xv_q    <= xv_d;
                  xrow_q  <= xrow_d;
                  xaddr_q <= xaddr_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (&cnt_q) begin
                  rep_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q   <= cnt_q + PCAM'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.repairable   = rep_q;
   assign bus.repair_mask  = mask_q;
   assign bus.rows_used    = rows_q;
   assign bus.cols_used    = cols_q;
   assign bus.extra_valid  = xv_q;
   assign bus.extra_is_row = xrow_q;
   assign bus.extra_addr   = xaddr_q;
endmodule

`default_nettype wire

// File: tb/tb_redundancy_analyzer_seq.sv
// ---------------------------------------------------------------------------
// tb_redundancy_analyzer_seq : directed and random checks against a
// brute-force search model of the repair rules.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_redundancy_analyzer_seq;
   localparam int PCAM      = 8;
   localparam int NPCAM     = 30;
   localparam int ROW_W     = 5;
   localparam int COL_W     = 5;
   localparam int SPARE_ROW = 4;
   localparam int SPARE_COL = 4;
   localparam int NCAND     = 1 << PCAM;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   redundancy_analyzer_seq_if #(.PCAM(PCAM), .NPCAM(NPCAM), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

   redundancy_analyzer_seq #(
      .PCAM(PCAM), .NPCAM(NPCAM), .ROW_W(ROW_W), .COL_W(COL_W),
      .SPARE_ROW(SPARE_ROW), .SPARE_COL(SPARE_COL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic             pv [PCAM];
   logic [ROW_W-1:0] pr [PCAM];
   logic [COL_W-1:0] pc [PCAM];
   logic             nv [NPCAM];
   logic [ROW_W-1:0] nr [NPCAM];
   logic [COL_W-1:0] nc [NPCAM];

   int n_checks = 0;
   int n_fail   = 0;

   int exp_rep, exp_mask, exp_r, exp_c, exp_xv, exp_xrow, exp_xaddr, exp_k;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_cam();
      for (int i = 0; i < PCAM; i++) begin pv[i] = 0; pr[i] = '0; pc[i] = '0; end
      for (int j = 0; j < NPCAM; j++) begin nv[j] = 0; nr[j] = '0; nc[j] = '0; end
   endtask

   task automatic random_cam(input int span);
      for (int i = 0; i < PCAM; i++) begin
         pv[i] = ($urandom_range(0, 1) == 1);
         pr[i] = ROW_W'($urandom_range(0, span));
         pc[i] = COL_W'($urandom_range(0, span));
      end
      for (int j = 0; j < NPCAM; j++) begin
         nv[j] = ($urandom_range(0, 5) == 0);
         nr[j] = ROW_W'($urandom_range(0, span));
         nc[j] = COL_W'($urandom_range(0, span));
      end
   endtask

   task automatic apply_cam();
      for (int i = 0; i < PCAM; i++) begin
         bus.pivot_valid[i]              = pv[i];
         bus.pivot_row[i*ROW_W +: ROW_W] = pr[i];
         bus.pivot_col[i*COL_W +: COL_W] = pc[i];
      end
      for (int j = 0; j < NPCAM; j++) begin
         bus.npivot_valid[j]              = nv[j];
         bus.npivot_row[j*ROW_W +: ROW_W] = nr[j];
         bus.npivot_col[j*COL_W +: COL_W] = nc[j];
      end
   endtask

   // Try every assignment in ascending order; first legal one wins.
   task automatic model();
      int  nrow, ncol, unc_n, unc_j;
      bit  ok, cov, found;
      exp_rep = 0; exp_mask = 0; exp_r = 0; exp_c = 0;
      exp_xv = 0; exp_xrow = 0; exp_xaddr = 0; exp_k = NCAND - 1;
      for (int m = 0; m < NCAND; m++) begin
         ok = 1; nrow = 0; ncol = 0; found = 0;
         for (int i = 0; i < PCAM; i++) begin
            if (((m >> i) & 1) == 1) begin
               if (!pv[i]) ok = 0; else nrow++;
            end else if (pv[i]) ncol++;
         end
         if (!ok || nrow > SPARE_ROW || ncol > SPARE_COL) continue;
         unc_n = 0; unc_j = 0;
         for (int j = 0; j < NPCAM; j++) begin
            if (!nv[j]) continue;
            cov = 0;
            for (int i = 0; i < PCAM; i++) begin
               if (pv[i] && ((((m >> i) & 1) == 1) ? (pr[i] == nr[j]) : (pc[i] == nc[j]))) cov = 1;
            end
            if (!cov) begin unc_n++; unc_j = j; end
         end
         if (unc_n == 0) found = 1;
`ifdef REMAIN_COVER_EN
         else if (unc_n == 1 && (SPARE_ROW - nrow) + (SPARE_COL - ncol) >= 1) begin
            found  = 1;
            exp_xv = 1;
            if (SPARE_ROW - nrow >= 1) begin exp_xrow = 1; exp_xaddr = int'(nr[unc_j]); end
            else                       begin exp_xrow = 0; exp_xaddr = int'(nc[unc_j]); end
         end
`endif
         if (found) begin
            exp_rep = 1; exp_mask = m; exp_r = nrow; exp_c = ncol; exp_k = m;
            break;
         end
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, ".repairable"},   32'(bus.repairable),   exp_rep);
      check({tag, ".repair_mask"},  32'(bus.repair_mask),  exp_mask);
      check({tag, ".rows_used"},    32'(bus.rows_used),    exp_r);
      check({tag, ".cols_used"},    32'(bus.cols_used),    exp_c);
      check({tag, ".extra_valid"},  32'(bus.extra_valid),  exp_xv);
      check({tag, ".extra_is_row"}, 32'(bus.extra_is_row), exp_xrow);
      check({tag, ".extra_addr"},   32'(bus.extra_addr),   exp_xaddr);
   endtask

   // Launch one analysis; optionally re-pulse start with new data at glitch_edge.
   task automatic run(input string tag, input int glitch_edge);
      int edges;
      model();
      apply_cam();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges = 1;
      check({tag, ".busy_rise"}, 32'(bus.busy), 1);
      while (!bus.done && edges < NCAND + 10) begin
         if (edges == glitch_edge) begin
            random_cam(3);
            apply_cam();
            bus.start = 1'b1;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         edges++;
      end
      check({tag, ".done_edge"}, 32'(edges), 32'(exp_k + 2));
      check({tag, ".done"}, 32'(bus.done), 1);
      check({tag, ".busy_at_done"}, 32'(bus.busy), 1);
      check_results(tag);
      @(posedge clk); #1;
      check({tag, ".done_fall"}, 32'(bus.done), 0);
      check({tag, ".busy_fall"}, 32'(bus.busy), 0);
      check_results({tag, ".hold"});
   endtask

   task automatic load_distinct_fail();
      clear_cam();
      for (int i = 0; i < PCAM; i++) begin
         pv[i] = 1; pr[i] = ROW_W'(i); pc[i] = COL_W'(i + 8);
      end
      nv[0] = 1; nr[0] = ROW_W'(20); nc[0] = COL_W'(21);
   endtask

   initial begin
      int pulses;
      bus.start = 1'b0;
      clear_cam();
      apply_cam();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_rep = 0; exp_mask = 0; exp_r = 0; exp_c = 0; exp_xv = 0; exp_xrow = 0; exp_xaddr = 0;
      check("reset.busy", 32'(bus.busy), 0);
      check("reset.done", 32'(bus.done), 0);
      check_results("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // No valid entries
      clear_cam();
      run("empty", 0);

      // Two pivots, one non-pivot sharing row 3 with pivot 0
      clear_cam();
      pv[0] = 1; pr[0] = 5'd3; pc[0] = 5'd7;
      pv[1] = 1; pr[1] = 5'd9; pc[1] = 5'd2;
      nv[0] = 1; nr[0] = 5'd3; nc[0] = 5'd11;
      run("two_pivot", 0);

      // Exhaustive search ending in failure
      load_distinct_fail();
      run("exhaust", 0);

      // Single pivot, unrelated non-pivot
      clear_cam();
      pv[0] = 1; pr[0] = 5'd1; pc[0] = 5'd1;
      nv[0] = 1; nr[0] = 5'd20; nc[0] = 5'd21;
      run("leftover", 0);

      // start re-pulsed mid-search with different data must be ignored
      load_distinct_fail();
      run("restart_ignored", 5);

      // Abort by reset during a long search
      load_distinct_fail();
      apply_cam();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort.busy", 32'(bus.busy), 0);
      check("abort.done", 32'(bus.done), 0);
      exp_rep = 0; exp_mask = 0; exp_r = 0; exp_c = 0; exp_xv = 0; exp_xrow = 0; exp_xaddr = 0;
      check_results("abort");
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int t = 0; t < NCAND + 10; t++) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      check("abort.no_done", 32'(pulses), 0);
      clear_cam();
      run("after_abort", 0);

      // Randomized CAM contents, narrow and full address spans
      for (int n = 0; n < 24; n++) begin
         random_cam((n % 3 == 2) ? 31 : 3);
         run($sformatf("rand%0d", n), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
